relayer_queue: RTL and testbench

Parametrised dual-issue relay stage between fetch and decode, successor to the combinational pair relayer. It buffers fetched instruction pairs in a DEPTH-entry circular queue, drops NOPs on entry, and checks the two oldest entries for RAW, WAW, memory-port and branch-serialisation hazards every cycle. It issues two instructions when the pair is independent, otherwise one, under a valid/ready handshake with decode.

---
 rtl/relayer_pkg.sv | 45 ++++
 rtl/relayer_queue_if.sv | 28 ++
 rtl/relayer_hazard.sv | 21 ++
 rtl/relayer_queue.sv | 89 ++++++++
 tb/tb_relayer_queue.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/relayer_pkg.sv
// Shared instruction field layout, opcodes and hazard helper predicates
// for the relay stage between fetch and decode.
package relayer_pkg;

   typedef logic [15:0] instr_t;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;

   localparam logic [3:0] OPC_LOAD   = 4'h8;
   localparam logic [3:0] OPC_STORE  = 4'h9;
   localparam logic [3:0] OPC_BRANCH = 4'hF;

   function automatic logic [3:0] get_opc(instr_t x);
      return x[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [3:0] get_rd(instr_t x);
      return x[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [3:0] get_rs1(instr_t x);
      return x[RS1_MSB:RS1_LSB];
   endfunction

   function automatic logic [3:0] get_rs2(instr_t x);
      return x[RS2_MSB:RS2_LSB];
   endfunction

   // An all-zero word is a NOP and never produces a result.
   function automatic logic writes_rd(instr_t x);
      return (get_opc(x) != OPC_STORE) && (get_opc(x) != OPC_BRANCH) && (x != '0);
   endfunction

   function automatic logic is_mem(instr_t x);
      return (get_opc(x) == OPC_LOAD) || (get_opc(x) == OPC_STORE);
   endfunction

endpackage

// File: rtl/relayer_queue_if.sv
// Fetch-side and decode-side handshake bundle of the relay queue.
interface relayer_queue_if #(parameter int IW = 16);

   logic          in_valid;
   logic [IW-1:0] in_instr0;
   logic [IW-1:0] in_instr1;
   logic          in_ready;
   logic          out_valid0;
   logic [IW-1:0] out_instr0;
   logic          out_valid1;
   logic [IW-1:0] out_instr1;
   logic          out_ready;
   logic          issingleinstr;
   logic          isstall;

   modport slave (
      input  in_valid, in_instr0, in_instr1, out_ready,
      output in_ready, out_valid0, out_instr0, out_valid1, out_instr1,
             issingleinstr, isstall
   );

   modport master (
      output in_valid, in_instr0, in_instr1, out_ready,
      input  in_ready, out_valid0, out_instr0, out_valid1, out_instr1,
             issingleinstr, isstall
   );

endinterface

// File: rtl/relayer_hazard.sv
// Pairwise dependency check between the two oldest queued instructions;
// any hazard forces single issue.
module relayer_hazard
   import relayer_pkg::*;
(
   input  instr_t a,
   input  instr_t b,
   output logic   hazard
);

   logic raw, waw, mem, ser;

   always_comb begin
      raw    = writes_rd(a) && ((get_rd(a) == get_rs1(b)) || (get_rd(a) == get_rs2(b)));
      waw    = writes_rd(a) && writes_rd(b) && (get_rd(a) == get_rd(b));
      mem    = is_mem(a) && is_mem(b);
      ser    = (get_opc(a) == OPC_BRANCH) || (get_opc(b) == OPC_BRANCH);
      hazard = raw || waw || mem || ser;
   end

endmodule

// File: rtl/relayer_queue.sv
// Circular relay queue: accepts fetch pairs, drops NOPs, and issues one or
// two of the oldest entries per cycle depending on their independence.
module relayer_queue
   import relayer_pkg::*;
#(
   parameter int IW       = 16,
   parameter int DEPTH    = 8,
   parameter bit DROP_NOP = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   relayer_queue_if.slave  q
);

   localparam int PW = $clog2(DEPTH);
   typedef logic [PW-1:0] ptr_t;
   typedef logic [PW:0]   cnt_t;

   logic [IW-1:0] mem_q [DEPTH];
   ptr_t          head_q, head_d, tail_q, tail_d;
   cnt_t          count_q, count_d;

   logic [IW-1:0] instr_a, instr_b;
   logic          hazard, valid0, valid1;
   logic          keep0, keep1, push, wr0_en, wr1_en;
   ptr_t          wr1_addr;
   logic [1:0]    push_n, pop_n;

   // Slot 1 wraps naturally because DEPTH is a power of two.
   assign instr_a = mem_q[head_q];
   assign instr_b = mem_q[head_q + ptr_t'(1)];

   relayer_hazard u_hazard (
      .a      (instr_a),
      .b      (instr_b),
      .hazard (hazard)
   );

   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
      valid0   = (count_q != '0);
      valid1   = (count_q >= cnt_t'(2)) && !hazard;
      keep0    = !(DROP_NOP && (q.in_instr0 == '0));
      keep1    = !(DROP_NOP && (q.in_instr1 == '0));
      push     = q.in_valid && q.in_ready && !flush;
      wr0_en   = push && keep0;
      wr1_en   = push && keep1;
      wr1_addr = keep0 ? tail_q + ptr_t'(1) : tail_q;
      push_n   = push ? ({1'b0, keep0} + {1'b0, keep1}) : 2'd0;
      pop_n    = (q.out_ready && !flush) ? ({1'b0, valid0} + {1'b0, valid1}) : 2'd0;
      head_d   = head_q + ptr_t'(pop_n);
      tail_d   = tail_q + ptr_t'(push_n);
      count_d  = count_q + cnt_t'(push_n) - cnt_t'(pop_n);
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; entries are only observed behind count_q.
   always_ff @(posedge clk) begin
      if (wr0_en) mem_q[tail_q]   <= q.in_instr0;
      if (wr1_en) mem_q[wr1_addr] <= q.in_instr1;
   end

   assign q.in_ready      = (count_q <= cnt_t'(DEPTH - 2));
   assign q.out_valid0    = valid0;
   assign q.out_valid1    = valid1;
   assign q.out_instr0    = valid0 ? instr_a : '0;
   assign q.out_instr1    = valid1 ? instr_b : '0;
   assign q.issingleinstr = valid0 && !valid1;
   assign q.isstall       = (count_q >= cnt_t'(2)) && hazard;

endmodule

// File: tb/tb_relayer_queue.sv
// Randomised bench for relayer_queue: a queue-based reference model is
// compared every cycle, plus directed literal checks that pin the model.
module tb_relayer_queue;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst, flush;

   relayer_queue_if #(.IW(16)) bus ();

   relayer_queue #(.IW(16), .DEPTH(DEPTH), .DROP_NOP(1'b1)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .q     (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp  = 0;
   int          n_fail = 0;
   bit          chk_en = 0;
   logic [15:0] mq[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_writes(logic [15:0] x);
      int op = int'(x >> 12);
      return (op != 9) && (op != 15) && (x != 16'h0);
   endfunction

   function automatic bit m_mem(logic [15:0] x);
      int op = int'(x >> 12);
      return (op == 8) || (op == 9);
   endfunction

   function automatic bit m_hazard(logic [15:0] a, logic [15:0] b);
      int ard  = int'((a >> 8) & 16'hF);
      int brd  = int'((b >> 8) & 16'hF);
      int brs1 = int'((b >> 4) & 16'hF);
      int brs2 = int'(b & 16'hF);
      bit raw  = m_writes(a) && (ard == brs1 || ard == brs2);
      bit waw  = m_writes(a) && m_writes(b) && (ard == brd);
      bit mem  = m_mem(a) && m_mem(b);
      bit ser  = (int'(a >> 12) == 15) || (int'(b >> 12) == 15);
      return raw || waw || mem || ser;
   endfunction

   // Reference model update at each rising edge.
   always @(posedge clk) begin : model
      int cnt;
      bit rdy;
      int popn;
      if (rst) begin
         mq.delete();
         chk_en = 1;
      end else if (flush) begin
         mq.delete();
      end else begin
         cnt  = mq.size();
         rdy  = (DEPTH - cnt) >= 2;
         popn = 0;
         if (bus.out_ready && cnt >= 1) begin
            popn = 1;
            if (cnt >= 2 && !m_hazard(mq[0], mq[1])) popn = 2;
         end
         repeat (popn) void'(mq.pop_front());
         if (bus.in_valid && rdy) begin
            if (bus.in_instr0 != 16'h0) mq.push_back(bus.in_instr0);
            if (bus.in_instr1 != 16'h0) mq.push_back(bus.in_instr1);
         end
      end
   end

   // Compare process, sampled on the falling edge.
   always @(negedge clk) begin : compare
      int          cnt;
      bit          hz, ev0, ev1;
      logic [15:0] ea, eb;
      if (chk_en) begin
         cnt = mq.size();
         ev0 = cnt >= 1;
         ea  = ev0 ? mq[0] : 16'h0;
         hz  = (cnt >= 2) ? m_hazard(mq[0], mq[1]) : 1'b0;
         ev1 = (cnt >= 2) && !hz;
         eb  = ev1 ? mq[1] : 16'h0;
         check("in_ready",      32'(bus.in_ready),      32'((DEPTH - cnt) >= 2));
         check("out_valid0",    32'(bus.out_valid0),    32'(ev0));
         check("out_instr0",    32'(bus.out_instr0),    32'(ea));
         check("out_valid1",    32'(bus.out_valid1),    32'(ev1));
         check("out_instr1",    32'(bus.out_instr1),    32'(eb));
         check("issingleinstr", 32'(bus.issingleinstr), 32'(ev0 && !ev1));
         check("isstall",       32'(bus.isstall),       32'((cnt >= 2) && hz));
      end
   end

   task automatic drive(bit v, logic [15:0] i0, logic [15:0] i1, bit ordy,
                        bit fl = 1'b0, bit r = 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_instr0 = i0;
      bus.in_instr1 = i1;
      bus.out_ready = ordy;
      flush         = fl;
      rst           = r;
   endtask

   function automatic logic [15:0] rand_word();
      logic [3:0] op;
      if ($urandom_range(7) == 0) return 16'h0;
      case ($urandom_range(5))
         0:       op = 4'h0;
         1:       op = 4'h1;
         2:       op = 4'h2;
         3:       op = 4'h8;
         4:       op = 4'h9;
         default: op = 4'hF;
      endcase
      return {op, 2'b00, 2'($urandom_range(3)), 2'b00, 2'($urandom_range(3)),
              2'b00, 2'($urandom_range(3))};
   endfunction

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr0 = 16'h0;
      bus.in_instr1 = 16'h0;
      bus.out_ready = 1'b0;

      // Reset values.
      drive(0, 16'h0, 16'h0, 0, 0, 1);
      drive(0, 16'h0, 16'h0, 0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_valid0",   32'(bus.out_valid0), 32'd0);
      check("rst_instr0",   32'(bus.out_instr0), 32'd0);
      check("rst_isstall",  32'(bus.isstall), 32'd0);

      // Independent pair: dual issue.
      drive(1, 16'h1234, 16'h5678, 1);
      drive(0, 16'h0, 16'h0, 1);
      check("pair_instr0", 32'(bus.out_instr0), 32'h1234);
      check("pair_instr1", 32'(bus.out_instr1), 32'h5678);
      check("pair_single", 32'(bus.issingleinstr), 32'd0);

      // RAW: B reads r2 written by A.
      drive(1, 16'h1234, 16'h3526, 1);
      drive(0, 16'h0, 16'h0, 1);
      check("raw_instr0", 32'(bus.out_instr0), 32'h1234);
      check("raw_stall",  32'(bus.isstall), 32'd1);
      check("raw_instr1", 32'(bus.out_instr1), 32'd0);
      drive(0, 16'h0, 16'h0, 1);
      check("raw_second", 32'(bus.out_instr0), 32'h3526);
      check("raw_single", 32'(bus.issingleinstr), 32'd1);

      // Two loads writing the same register.
      drive(1, 16'h8F34, 16'h8F78, 1);
      drive(0, 16'h0, 16'h0, 1);
      check("ld_instr0", 32'(bus.out_instr0), 32'h8F34);
      check("ld_stall",  32'(bus.isstall), 32'd1);
      drive(0, 16'h0, 16'h0, 1);
      check("ld_second", 32'(bus.out_instr0), 32'h8F78);
      check("ld_nostall", 32'(bus.isstall), 32'd0);

      // Fill to full across the pointer wrap, then drain.
      for (int i = 0; i < 4; i++)
         drive(1, {4'h1, 4'(2*i), 8'hEF}, {4'h1, 4'(2*i+1), 8'hEF}, 0);
      drive(1, 16'h1AEF, 16'h1BEF, 0);
      check("full_ready", 32'(bus.in_ready), 32'd0);
      drive(0, 16'h0, 16'h0, 1);
      check("wrap_instr0", 32'(bus.out_instr0), 32'h10EF);
      check("wrap_instr1", 32'(bus.out_instr1), 32'h11EF);
      for (int i = 0; i < 4; i++) drive(0, 16'h0, 16'h0, 1);
      check("drained", 32'(bus.out_valid0), 32'd0);

      // NOP drop, then flush with a concurrent push.
      drive(1, 16'h1234, 16'h0000, 0);
      drive(1, 16'h1111, 16'h2222, 0, 1);
      check("nop_single", 32'(bus.issingleinstr), 32'd1);
      check("nop_valid1", 32'(bus.out_valid1), 32'd0);
      drive(0, 16'h0, 16'h0, 0);
      check("flush_empty", 32'(bus.out_valid0), 32'd0);

      // Count 7 blocks fetch; reset mid-drain at count 5.
      drive(1, 16'h1012, 16'h1134, 0);
      drive(1, 16'h1256, 16'h1378, 0);
      drive(1, 16'h149A, 16'h15BC, 0);
      drive(1, 16'h16DE, 16'h0000, 0);
      drive(0, 16'h0, 16'h0, 1);
      check("cnt7_ready", 32'(bus.in_ready), 32'd0);
      drive(0, 16'h0, 16'h0, 1, 0, 1);
      drive(0, 16'h0, 16'h0, 1);
      check("rst2_ready",  32'(bus.in_ready), 32'd1);
      check("rst2_valid0", 32'(bus.out_valid0), 32'd0);

      // Random traffic.
      for (int n = 0; n < 3000; n++)
         drive($urandom_range(3) != 0, rand_word(), rand_word(),
               $urandom_range(9) < 7, $urandom_range(59) == 0,
               $urandom_range(399) == 0);

      drive(0, 16'h0, 16'h0, 1);
      @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
